// File: rtl/nco_phase.sv
// Phase-accumulator NCO with square/triangle outputs and a glitch-free increment
// update path that defers new increments to the accumulator wrap.
module nco_phase #(
    parameter int ACC_W    = 16,
    parameter int SAFE_UPD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] phinc,
    input  logic       en,
    output logic [7:0] phase,
    output logic       sq_out,
    output logic [7:0] tri_out,
    output logic       tick,
    output logic [7:0] inc_act,
    output logic       upd_pend
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;
    localparam logic       P_SAFE = (SAFE_UPD != 0);

    if (ACC_W < 9 || ACC_W > 32) begin : g_bad_width
        $error("nco_phase: ACC_W must be in 9..32");
    end

    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_req;
    logic [0:0]       r_state;

    logic [ACC_W:0]   w_sum;
    logic             w_wrap;
    logic             w_diff;
    logic             w_load;
    logic [6:0]       w_ph_lo;
    logic [7:0]       w_tri;

    assign w_sum   = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, inc_act};
    assign w_wrap  = en & w_sum[ACC_W];
    assign w_diff  = (phinc != inc_act);
    // A stopped NCO (inc_act==0) would never wrap, so it loads immediately.
    assign w_load  = (inc_act == 8'd0) | ~P_SAFE | w_wrap;
    assign w_ph_lo = r_acc[ACC_W-2 -: 7];
    assign w_tri   = r_acc[ACC_W-1] ? ~{w_ph_lo, 1'b0} : {w_ph_lo, 1'b0};

    assign upd_pend = (r_state == S_PEND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            tick    <= 1'b0;
            phase   <= 8'd0;
            sq_out  <= 1'b0;
            tri_out <= 8'd0;
        end else begin
            if (en) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            tick    <= w_wrap;
            phase   <= r_acc[ACC_W-1 -: 8];
            sq_out  <= r_acc[ACC_W-1];
            tri_out <= w_tri;
        end
    end

    // Wrap and load in the same cycle: the carrying addition above still uses the old inc_act.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_req   <= 8'd0;
            inc_act <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_diff) begin
                        r_state <= S_PEND;
                        r_req   <= phinc;
                    end
                end
                default: begin
                    r_req <= phinc;
                    if (!w_diff) begin
                        r_state <= S_IDLE;
                    end else if (w_load) begin
                        inc_act <= r_req;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
